// File: rtl/rs232_mem_ctrl_if.sv
// rs232_mem_ctrl_if: byte-stream and memory-bus bundle between the command
// front-end (master) and its surroundings: UART RX/TX and the memory macro
// (slave).
//   rx_data/rx_valid       : received byte strobe from the UART receiver
//   tx_data/tx_valid/ready : byte to the UART transmitter, valid/ready
//   mem_addr/mem_write/
//   mem_data_in/out        : memory macro port
//   busy                   : front-end is executing, not collecting bytes
interface rs232_mem_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [7:0]        mem_data_in;
    logic [7:0]        mem_data_out;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_data_out,
        output tx_data, tx_valid, mem_addr, mem_write, mem_data_in, busy
    );
    modport slave (
        output rx_data, rx_valid, tx_ready, mem_data_out,
        input  tx_data, tx_valid, mem_addr, mem_write, mem_data_in, busy
    );
endinterface

// File: rtl/rs232_mem_ctrl.sv
// rs232_mem_ctrl: decodes write ('W' hi lo data) and read ('R' hi lo)
// commands from the UART byte stream and drives the memory macro; read data
// goes back to the transmitter over valid/ready.
// Ports: clk, rst (async, active high), bus (rs232_mem_ctrl_if.master).
// All outputs are registered.
// Optional: define RS232_MEM_CTRL_ACK_EN to answer writes with 8'h06 and
// unknown opcodes with 8'h15 on the tx side.
module rs232_mem_ctrl #(
    parameter int         ADDR_W     = 14,
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] OP_WR      = 8'h57,
    parameter logic [7:0] OP_RD      = 8'h52
) (
    input  logic              clk,
    input  logic              rst,
    rs232_mem_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, DATA, WRITE, RD_WAIT, TX
    } state_t;

    localparam int HI_W = ADDR_W - 8;

    state_t            state, state_n;
    logic              cmd_wr, cmd_wr_n;
    logic [HI_W-1:0]   addr_hi, addr_hi_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              we_q, we_n;
    logic [7:0]        din_q, din_n;
    logic [7:0]        txd_q, txd_n;
    logic              txv_q, txv_n;
    logic              busy_q, busy_n;
    logic [2:0]        cnt_q, cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cmd_wr  <= 1'b0;
            addr_hi <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            cmd_wr  <= cmd_wr_n;
            addr_hi <= addr_hi_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            din_q   <= din_n;
            txd_q   <= txd_n;
            txv_q   <= txv_n;
            busy_q  <= busy_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cmd_wr_n  = cmd_wr;
        addr_hi_n = addr_hi;
        addr_n    = addr_q;
        we_n      = 1'b0;    // write strobe lives for the WRITE cycle only
        din_n     = din_q;
        txd_n     = txd_q;
        txv_n     = txv_q;
        cnt_n     = cnt_q;
        case (state)
            IDLE: if (bus.rx_valid) begin
                if (bus.rx_data == OP_WR) begin
                    cmd_wr_n = 1'b1;
                    state_n  = ADDR_HI;
                end else if (bus.rx_data == OP_RD) begin
                    cmd_wr_n = 1'b0;
                    state_n  = ADDR_HI;
                end else begin
`ifdef RS232_MEM_CTRL_ACK_EN
                    txd_n   = 8'h15;
                    txv_n   = 1'b1;
                    state_n = TX;
`endif
                end
            end
            ADDR_HI: if (bus.rx_valid) begin
                // Upper bits beyond the address width are dropped here.
                addr_hi_n = bus.rx_data[HI_W-1:0];
                state_n   = ADDR_LO;
            end
            ADDR_LO: if (bus.rx_valid) begin
                addr_n = {addr_hi, bus.rx_data};
                if (cmd_wr) begin
                    state_n = DATA;
                end else begin
                    cnt_n   = 3'(RD_LATENCY);
                    state_n = RD_WAIT;
                end
            end
            DATA: if (bus.rx_valid) begin
                din_n   = bus.rx_data;
                we_n    = 1'b1;
                state_n = WRITE;
            end
            WRITE: begin
`ifdef RS232_MEM_CTRL_ACK_EN
                txd_n   = 8'h06;
                txv_n   = 1'b1;
                state_n = TX;
`else
                state_n = IDLE;
`endif
            end
            RD_WAIT: begin
                // Counter loaded with RD_LATENCY; sampling at zero lands one
                // edge after the macro's data is valid.
                if (cnt_q == 3'd0) begin
                    txd_n   = bus.mem_data_out;
                    txv_n   = 1'b1;
                    state_n = TX;
                end else begin
                    cnt_n = cnt_q - 3'd1;
                end
            end
            TX: if (bus.tx_ready) begin
                txv_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = !(state_n inside {IDLE, ADDR_HI, ADDR_LO, DATA});
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_write   = we_q;
    assign bus.mem_data_in = din_q;
    assign bus.tx_data     = txd_q;
    assign bus.tx_valid    = txv_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_rs232_mem_ctrl.sv
// Directed bench for rs232_mem_ctrl with a one-cycle synchronous memory model.
module tb_rs232_mem_ctrl;
    localparam int ADDR_W = 14;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    rs232_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    rs232_mem_ctrl #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: write on mem_write, registered read data (latency 1).
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (rst) mem[5] <= 8'hC3;
        else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
        rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_data_out = rd_q;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // One-cycle tx_ready pulse; transfer completes at the next edge.
    task automatic drain();
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("drain_txv", 16'(bus.tx_valid), 16'd0);
        chk("drain_busy", 16'(bus.busy), 16'd0);
    endtask

    // Called right after the WRITE cycle has ended.
    task automatic after_write();
`ifdef RS232_MEM_CTRL_ACK_EN
        chk("ack_valid", 16'(bus.tx_valid), 16'd1);
        chk("ack_data", 16'(bus.tx_data), 16'h06);
        drain();
`else
        chk("wr_no_tx", 16'(bus.tx_valid), 16'd0);
        chk("wr_idle", 16'(bus.busy), 16'd0);
`endif
    endtask

    initial begin
        int n;
        logic [7:0] hold_d;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;

        // Bytes during reset are ignored
        send(8'h57);
        send(8'h00);
        chk("rst_addr", 16'(bus.mem_addr), 16'h0000);
        chk("rst_we", 16'(bus.mem_write), 16'd0);
        chk("rst_din", 16'(bus.mem_data_in), 16'h00);
        chk("rst_txd", 16'(bus.tx_data), 16'h00);
        chk("rst_txv", 16'(bus.tx_valid), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);

        // Partial write, then asynchronous reset pulse
        @(negedge clk) rst = 1'b0;
        send(8'h57);
        send(8'h00);
        #2 rst = 1'b1;
        #1 chk("async_rst_we", 16'(bus.mem_write), 16'd0);
        @(negedge clk) rst = 1'b0;

        // Read of preset address 5
        send(8'h52);
        send(8'h00);
        send(8'h05);
        chk("rd5_addr", 16'(bus.mem_addr), 16'h0005);
        chk("rd5_busy", 16'(bus.busy), 16'd1);
        chk("rd5_txv0", 16'(bus.tx_valid), 16'd0);
        @(negedge clk);
        chk("rd5_txv1", 16'(bus.tx_valid), 16'd0);
        chk("rd5_we", 16'(bus.mem_write), 16'd0);
        @(negedge clk);
        chk("rd5_txv2", 16'(bus.tx_valid), 16'd1);
        chk("rd5_data", 16'(bus.tx_data), 16'h00C3);
        drain();

        // Write 0x1234 <= 0xA5
        send(8'h57);
        send(8'h12);
        send(8'h34);
        chk("wr_busy_pre", 16'(bus.busy), 16'd0);
        send(8'hA5);
        chk("wr_we", 16'(bus.mem_write), 16'd1);
        chk("wr_addr", 16'(bus.mem_addr), 16'h1234);
        chk("wr_din", 16'(bus.mem_data_in), 16'h00A5);
        chk("wr_busy", 16'(bus.busy), 16'd1);
        @(negedge clk);
        chk("wr_we_off", 16'(bus.mem_write), 16'd0);
        chk("wr_mem", 16'(mem[16'h1234]), 16'h00A5);
        after_write();

        // Write to top address with junk high bits, then read it back
        send(8'h57);
        send(8'h3F);
        send(8'hFF);
        send(8'h5A);
        chk("wr2_addr", 16'(bus.mem_addr), 16'h3FFF);
        @(negedge clk);
        after_write();
        send(8'h52);
        send(8'hFF);
        send(8'hFF);
        chk("rd2_addr", 16'(bus.mem_addr), 16'h3FFF);
        n = 0;
        while (!bus.tx_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rd2_latency", 16'(n), 16'(RD_LAT + 1));
        chk("rd2_data", 16'(bus.tx_data), 16'h005A);

        // Backpressure: 20 cycles with tx_ready low, bytes thrown at it
        hold_d = bus.tx_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.rx_valid = (i % 3 == 0);
            bus.rx_data  = (i % 2 == 0) ? 8'h57 : 8'h01;
            chk("bp_txv", 16'(bus.tx_valid), 16'd1);
            chk("bp_txd", 16'(bus.tx_data), 16'(hold_d));
            chk("bp_busy", 16'(bus.busy), 16'd1);
            chk("bp_we", 16'(bus.mem_write), 16'd0);
        end
        @(negedge clk) bus.rx_valid = 1'b0;
        drain();
        chk("bp_addr_kept", 16'(bus.mem_addr), 16'h3FFF);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("ready_idle_txv", 16'(bus.tx_valid), 16'd0);
        bus.tx_ready = 1'b0;

        // Bad opcode then a valid write
        send(8'h41);
`ifdef RS232_MEM_CTRL_ACK_EN
        chk("nak_valid", 16'(bus.tx_valid), 16'd1);
        chk("nak_data", 16'(bus.tx_data), 16'h15);
        drain();
`else
        chk("bad_busy", 16'(bus.busy), 16'd0);
        chk("bad_txv", 16'(bus.tx_valid), 16'd0);
`endif
        send(8'h57);
        send(8'h00);
        send(8'h00);
        send(8'h11);
        chk("wr3_we", 16'(bus.mem_write), 16'd1);
        chk("wr3_addr", 16'(bus.mem_addr), 16'h0000);
        chk("wr3_din", 16'(bus.mem_data_in), 16'h0011);
        @(negedge clk);
        chk("wr3_we_off", 16'(bus.mem_write), 16'd0);
        after_write();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
